fg_cfg_writer: RTL and testbench

FG_CFG_WRITER -- requirements
Module: fg_cfg_writer

---
 rtl/fg_cfg_pkg.sv | 39 +++
 rtl/fg_cfg_phase_timer.sv | 32 +++
 rtl/fg_cfg_writer.sv | 148 ++++++++++++++
 tb/tb_fg_cfg_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_cfg_pkg.sv
// Shared definitions for the frequency-generator configuration writer.
// Holds register-file geometry, the writer FSM state encoding and small
// helpers for selecting register bytes and walking the write mask.
package fg_cfg_pkg;

  localparam int unsigned NUM_REGS = 7;
  localparam int unsigned CR_W     = 8;
  localparam int unsigned CFG_W    = NUM_REGS * CR_W;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned PHASE_W  = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDisable = 3'd1,
    StSetup   = 3'd2,
    StStrobe  = 3'd3,
    StHold    = 3'd4,
    StDone    = 3'd5
  } fg_state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_REGS-1:0] m);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i]) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

  // CR0 sits in the most significant byte of the packed configuration word.
  function automatic logic [CR_W-1:0] cfg_byte(input logic [CFG_W-1:0]  cfg,
                                               input logic [ADDR_W-1:0] idx);
    int unsigned lsb;
    lsb = CR_W * (NUM_REGS - 1 - 32'(idx));
    return CR_W'(cfg >> lsb);
  endfunction

endpackage

// File: rtl/fg_cfg_phase_timer.sv
// Phase timer for the configuration writer.
// A 4-bit down-counter: load_i copies load_val_i in, otherwise it counts
// down and parks at zero. zero_o flags the last cycle of a phase.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : load strobe
//   load_val_i    : phase length minus one
//   zero_o        : counter is zero
module fg_cfg_phase_timer
  import fg_cfg_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [PHASE_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [PHASE_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fg_cfg_writer.sv
// Configuration writer for the frequency generator's register file.
// On start, disables the generator, then for each set mask bit (lowest
// first) presents address/data, pulses the active-low write strobe and
// holds the bus long enough for the generator's WR synchronizer, then
// restores the requested enable and pulses done. All outputs registered.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   start_i       : request an update (honoured only when idle)
//   cfg_i         : {CR0..CR6}, CR0 in bits 55:48
//   mask_i        : bit k selects CRk
//   run_i         : desired generator run state
//   busy_o/done_o : update in progress / one-cycle completion pulse
//   data_o/addr_o : register bus
//   wr_n_o        : active-low write strobe
//   enable_n_o    : active-low generator enable
module fg_cfg_writer
  import fg_cfg_pkg::*;
#(
  parameter int unsigned DIS_CYCLES   = 3,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned WR_CYCLES    = 2,
  parameter int unsigned HOLD_CYCLES  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [CFG_W-1:0]    cfg_i,
  input  logic [NUM_REGS-1:0] mask_i,
  input  logic                run_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CR_W-1:0]     data_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic                wr_n_o,
  output logic                enable_n_o
);

  fg_state_e           state_q;
  logic [CFG_W-1:0]    cfg_q;
  logic [NUM_REGS-1:0] pend_q;  // registers still to be written
  logic                run_q;

  logic               tmr_load;
  logic [PHASE_W-1:0] tmr_val;
  logic               tmr_zero;
  logic [ADDR_W-1:0]  next_idx;

  assign next_idx = lowest_set(pend_q);

  // Reload whenever a phase ends; the value is the length of the phase
  // the FSM enters next. Idle keeps the disable length preloaded.
  always_comb begin
    tmr_load = (state_q == StIdle) || tmr_zero;
    tmr_val  = '0;
    unique case (state_q)
      StIdle:            tmr_val = PHASE_W'(DIS_CYCLES - 1);
      StDisable, StHold: tmr_val = PHASE_W'(SETUP_CYCLES - 1);
      StSetup:           tmr_val = PHASE_W'(WR_CYCLES - 1);
      StStrobe:          tmr_val = PHASE_W'(HOLD_CYCLES - 1);
      default:           tmr_val = '0;
    endcase
  end

  fg_cfg_phase_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cfg_q      <= '0;
      pend_q     <= '0;
      run_q      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      data_o     <= '0;
      addr_o     <= '0;
      wr_n_o     <= 1'b1;
      enable_n_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          enable_n_o <= ~run_i;
          wr_n_o     <= 1'b1;
          busy_o     <= 1'b0;
          if (start_i) begin
            cfg_q  <= cfg_i;
            pend_q <= mask_i;
            run_q  <= run_i;
            busy_o <= 1'b1;
            if (mask_i == '0) begin
              state_q <= StDone;
              done_o  <= 1'b1;
            end else begin
              state_q    <= StDisable;
              enable_n_o <= 1'b1;
            end
          end
        end
        StDisable: begin
          if (tmr_zero) begin
            state_q <= StSetup;
            addr_o  <= next_idx;
            data_o  <= cfg_byte(cfg_q, next_idx);
            pend_q  <= pend_q & ~(NUM_REGS'(1) << next_idx);
          end
        end
        StSetup: begin
          if (tmr_zero) begin
            state_q <= StStrobe;
            wr_n_o  <= 1'b0;
          end
        end
        StStrobe: begin
          if (tmr_zero) begin
            state_q <= StHold;
            wr_n_o  <= 1'b1;
          end
        end
        StHold: begin
          if (tmr_zero) begin
            if (pend_q == '0) begin
              state_q    <= StDone;
              done_o     <= 1'b1;
              enable_n_o <= ~run_q;
            end else begin
              state_q <= StSetup;
              addr_o  <= next_idx;
              data_o  <= cfg_byte(cfg_q, next_idx);
              pend_q  <= pend_q & ~(NUM_REGS'(1) << next_idx);
            end
          end
        end
        StDone: begin
          state_q    <= StIdle;
          busy_o     <= 1'b0;
          enable_n_o <= ~run_i;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fg_cfg_writer.sv
// Directed bench for fg_cfg_writer with a generator-side synchronizer model
// and a write scoreboard.
module tb_fg_cfg_writer;

  localparam int WR_CYC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        run = 1'b1;
  logic [55:0] cfg = '0;
  logic [6:0]  mask = '0;
  logic        busy, done, wr_n, enable_n;
  logic [7:0]  data;
  logic [2:0]  addr;

  always #5 clk = ~clk;

  fg_cfg_writer #(
    .DIS_CYCLES   (3),
    .SETUP_CYCLES (2),
    .WR_CYCLES    (2),
    .HOLD_CYCLES  (4)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .cfg_i      (cfg),
    .mask_i     (mask),
    .run_i      (run),
    .busy_o     (busy),
    .done_o     (done),
    .data_o     (data),
    .addr_o     (addr),
    .wr_n_o     (wr_n),
    .enable_n_o (enable_n)
  );

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } exp_t;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] w;
    logic       stable;
    logic       aborted;
  } obs_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  obs_t obs[$];
  int   obs_rd = 0;
  logic [7:0] exp_reg [7];
  bit   abort_strobe = 1'b0;

  // Generator model: 3-stage WR synchronizer, 2-stage enable synchronizer,
  // register captured on the synchronized rising edge of WR while disabled.
  logic [2:0] wr_sync = 3'b111;
  logic [1:0] en_sync = 2'b11;
  logic [7:0] gen_reg [7] = '{default: 8'h00};

  always @(posedge clk) begin
    wr_sync <= {wr_sync[1:0], wr_n};
    en_sync <= {en_sync[0], enable_n};
    if (wr_sync[1] && !wr_sync[2] && en_sync[1] && addr < 3'd7) gen_reg[addr] <= data;
  end

  // Bus monitor: records each strobe, its width and bus stability.
  int         done_cnt = 0;
  int         strobe_cnt = 0;
  int         viol = 0;
  logic       wr_prev = 1'b1;
  logic [7:0] low_cnt = '0;
  logic [2:0] cur_a = '0;
  logic [7:0] cur_d = '0;
  logic       stable_ok = 1'b1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (!wr_n && !enable_n) viol <= viol + 1;
    if (!wr_n && wr_prev) begin
      strobe_cnt <= strobe_cnt + 1;
      low_cnt    <= 8'd1;
      cur_a      <= addr;
      cur_d      <= data;
      stable_ok  <= 1'b1;
    end else if (!wr_n) begin
      low_cnt <= low_cnt + 8'd1;
      if (addr !== cur_a || data !== cur_d) stable_ok <= 1'b0;
    end else if (!wr_prev) begin
      obs.push_back('{a: cur_a, d: cur_d, w: low_cnt, stable: stable_ok,
                      aborted: abort_strobe});
    end
    wr_prev <= wr_n;
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [6:0] m, input logic [55:0] c);
    logic [63:0] sh;
    for (int k = 0; k < 7; k++) begin
      if (m[k]) begin
        sh = {8'h00, c} >> (8 * (6 - k));
        sb.push_back('{a: 3'(k), d: sh[7:0]});
        exp_reg[k] = sh[7:0];
      end
    end
  endtask

  task automatic drain(input string tag);
    obs_t o;
    exp_t e;
    while (obs_rd < obs.size()) begin
      o = obs[obs_rd];
      obs_rd++;
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_addr"}, o.a, e.a);
        chk({tag, "_data"}, o.d, e.d);
        if (!o.aborted) begin
          chk({tag, "_wr_width"}, o.w, WR_CYC);
          chk({tag, "_bus_stable"}, o.stable, 1);
        end
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 7; k++) chk($sformatf("%s_cr%0d", tag, k), gen_reg[k], exp_reg[k]);
  endtask

  // Accepts at the first edge; latency = edges counted up to done_o.
  task automatic run_cfg(input logic [6:0] m, input logic [55:0] c, input logic r,
                         input bit repulse, output int lat, output int busy_lo);
    bit pulsed;
    push_expected(m, c);
    cfg = c; mask = m; run = r; start = 1'b1;
    lat = 0; busy_lo = 0; pulsed = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      start = 1'b0;
      if (repulse && !pulsed && !wr_n) begin
        start = 1'b1; mask = 7'h00; pulsed = 1'b1;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_lo++;
    end
    start = 1'b0;
  endtask

  initial begin
    int         lat, busy_lo, s0, d0;
    bit         found;
    logic [63:0] rnd;
    for (int k = 0; k < 7; k++) exp_reg[k] = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_enable_n", enable_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);

    // Full write, start in the first cycle after reset release
    rst = 1'b0;
    run_cfg(7'h7F, 56'h49_05_00_00_00_32_00, 1'b1, 1'b0, lat, busy_lo);
    chk("A_latency", lat, 60);
    chk("A_busy_run", busy_lo, 0);
    chk("A_busy_done", busy, 1);
    chk("A_enable_done", enable_n, 0);
    tick();
    chk("A_done_pulse", done, 0);
    chk("A_busy_idle", busy, 0);
    chk("A_enable_idle", enable_n, 0);
    drain("A");
    check_regs("A");

    // Sparse mask: CR0 and CR5 only
    rnd = {$urandom(), $urandom()};
    run_cfg(7'b0100001, rnd[55:0], 1'b1, 1'b0, lat, busy_lo);
    chk("B_latency", lat, 20);
    chk("B_busy_run", busy_lo, 0);
    tick();
    drain("B");
    check_regs("B");

    // Empty mask with run low: done next cycle, no bus activity
    run = 1'b0;
    tick(); tick();
    chk("C_enable_pre", enable_n, 1);
    s0 = strobe_cnt;
    run_cfg(7'h00, 56'hFF_FF_FF_FF_FF_FF_FF, 1'b0, 1'b0, lat, busy_lo);
    chk("C_latency", lat, 1);
    chk("C_enable_done", enable_n, 1);
    chk("C_busy_done", busy, 1);
    tick();
    chk("C_enable_idle", enable_n, 1);
    chk("C_done_pulse", done, 0);
    chk("C_no_strobe", strobe_cnt, s0);

    // Start re-pulsed during a strobe is ignored
    d0 = done_cnt;
    rnd = {$urandom(), $urandom()};
    run_cfg(7'h7F, rnd[55:0], 1'b1, 1'b1, lat, busy_lo);
    chk("D_latency", lat, 60);
    repeat (30) tick();
    chk("D_one_done", done_cnt - d0, 1);
    chk("D_idle", busy, 0);
    drain("D");
    check_regs("D");

    // Reset during the strobe of CR3
    rnd = {$urandom(), $urandom()};
    push_expected(7'h7F, rnd[55:0]);
    cfg = rnd[55:0]; mask = 7'h7F; run = 1'b1; start = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      start = 1'b0;
      if (!wr_n && addr == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("E_reached_cr3", found, 1);
    abort_strobe = 1'b1;
    rst = 1'b1;
    d0 = done_cnt;
    tick();
    chk("E_wr_n", wr_n, 1);
    chk("E_enable_n", enable_n, 1);
    chk("E_busy", busy, 0);
    chk("E_done", done, 0);
    chk("E_addr", addr, 0);
    rst = 1'b0;
    repeat (8) tick();
    chk("E_no_done", done_cnt - d0, 0);
    chk("E_busy_after", busy, 0);
    abort_strobe = 1'b0;
    drain("E");
    chk("E_strobes_before_rst", sb.size(), 3);
    sb.delete();

    // Recovery: full write after the aborted update
    rnd = {$urandom(), $urandom()};
    run_cfg(7'h7F, rnd[55:0], 1'b1, 1'b0, lat, busy_lo);
    chk("F_latency", lat, 60);
    tick();
    drain("F");
    check_regs("F");

    chk("enable_low_during_wr", viol, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
